// File: rtl/dtcm_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// dtcm_ctrl_pkg
// Shared sizing constants for the data tightly-coupled memory path.
//   XLEN            : core data width (the DTCM word is always one XLEN word)
//   DTCM_ADDR_WIDTH : width of the byte address presented by the LSU
// ----------------------------------------------------------------------------
package dtcm_ctrl_pkg;

  localparam int XLEN            = 32;
  localparam int DTCM_ADDR_WIDTH = 16;

endpackage

// File: rtl/gnrl_sram_1p.sv
// ----------------------------------------------------------------------------
// gnrl_sram_1p
// Generic single-port word SRAM with per-byte write enables and a registered
// read port. This behavioural array stands in for the vendor macro wrapper.
// Ports:
//   clk  : clock, all activity on the rising edge
//   cs   : chip select; nothing happens while low
//   we   : 1 = write, 0 = read
//   wem  : byte write enables (one bit per 8-bit lane), used only on writes
//   addr : word index
//   din  : write data
//   dout : read data register, updated only by a read (cs & ~we)
// ----------------------------------------------------------------------------
module gnrl_sram_1p #(
  parameter int DW = 32,
  parameter int DP = 16384,
  parameter int MW = DW / 8,
  localparam int AWI = (DP > 1) ? $clog2(DP) : 1
) (
  input  logic           clk,
  input  logic           cs,
  input  logic           we,
  input  logic [MW-1:0]  wem,
  input  logic [AWI-1:0] addr,
  input  logic [DW-1:0]  din,
  output logic [DW-1:0]  dout
);

  logic [DW-1:0] mem [DP];
  logic [DW-1:0] dout_q;

  // Contents and output register are deliberately not reset, like the macro.
  // A write leaves dout_q alone so the last read word stays visible.
  always_ff @(posedge clk) begin
    if (cs && we) begin
      for (int i = 0; i < MW; i++) begin
        if (wem[i]) begin
          mem[addr][i*8 +: 8] <= din[i*8 +: 8];
        end
      end
    end
    if (cs && !we) begin
      dout_q <= mem[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/dtcm_ctrl.sv
// ----------------------------------------------------------------------------
// dtcm_ctrl
// Responder end of the LSU-to-DTCM command/response interface. One read or
// byte-masked write is accepted at a time, performed on a single-port SRAM,
// and answered by exactly one response the cycle after acceptance. A hold
// register keeps the response stable while the LSU applies backpressure.
// Ports:
//   clk, rst_n      : clock and asynchronous active-low reset
//   dtcm_cmd_valid  : command valid from the LSU
//   dtcm_cmd_ready  : command accepted when valid & ready
//   dtcm_cmd_read   : 1 = read, 0 = write
//   dtcm_cmd_addr   : byte address, bits [1:0] ignored
//   dtcm_cmd_wdata  : lane-aligned write data
//   dtcm_cmd_wmask  : byte write enables (writes only)
//   dtcm_rsp_valid  : response valid
//   dtcm_rsp_ready  : response consumed when valid & ready
//   dtcm_rsp_rdata  : read word, 0 for write responses
// ----------------------------------------------------------------------------
module dtcm_ctrl
  import dtcm_ctrl_pkg::*;
#(
  parameter int DW = XLEN,
  parameter int AW = DTCM_ADDR_WIDTH,
  parameter int DP = 2 ** (AW - 2)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dtcm_cmd_valid,
  output logic            dtcm_cmd_ready,
  input  logic            dtcm_cmd_read,
  input  logic [AW-1:0]   dtcm_cmd_addr,
  input  logic [DW-1:0]   dtcm_cmd_wdata,
  input  logic [DW/8-1:0] dtcm_cmd_wmask,
  output logic            dtcm_rsp_valid,
  input  logic            dtcm_rsp_ready,
  output logic [DW-1:0]   dtcm_rsp_rdata
);

  localparam int IW = (DP > 1) ? $clog2(DP) : 1;

  // IDLE: nothing pending. RSP: response driven straight from the SRAM
  // output. HOLD: response stalled, driven from the hold register.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RSP  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          is_read_q, is_read_d;
  logic [DW-1:0] hold_q, hold_d;

  logic          cmd_hsk;
  logic [DW-1:0] sram_dout;
  logic [DW-1:0] rsp_word;
  logic          unused_addr_bits;

  // Byte-offset bits and any index bits above the SRAM depth are dropped,
  // so the word index simply wraps.
  assign unused_addr_bits = ^dtcm_cmd_addr;

  // Ready is combinational on rsp_ready so a retiring response and the next
  // command can share a cycle, giving one command per cycle.
  assign dtcm_cmd_ready = (state_q == IDLE) | dtcm_rsp_ready;
  assign cmd_hsk        = dtcm_cmd_valid & dtcm_cmd_ready;

  gnrl_sram_1p #(
    .DW (DW),
    .DP (DP),
    .MW (DW / 8)
  ) u_sram (
    .clk  (clk),
    .cs   (cmd_hsk),
    .we   (~dtcm_cmd_read),
    .wem  (dtcm_cmd_wmask),
    .addr (dtcm_cmd_addr[IW+1:2]),
    .din  (dtcm_cmd_wdata),
    .dout (sram_dout)
  );

  // The SRAM output register is only meaningful for reads; writes answer 0.
  assign rsp_word = is_read_q ? sram_dout : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      is_read_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      is_read_q <= is_read_d;
      hold_q    <= hold_d;
    end
  end

  // Next state and response outputs. rsp_valid depends on state only, never
  // on cmd_valid. When RSP is not consumed the word is captured into hold_q
  // because the next read would overwrite the SRAM output register.
  always_comb begin
    state_d        = state_q;
    is_read_d      = is_read_q;
    hold_d         = hold_q;
    dtcm_rsp_valid = 1'b0;
    dtcm_rsp_rdata = '0;

    case (state_q)
      IDLE: begin
        if (cmd_hsk) begin
          state_d   = RSP;
          is_read_d = dtcm_cmd_read;
        end
      end

      RSP: begin
        dtcm_rsp_valid = 1'b1;
        dtcm_rsp_rdata = rsp_word;
        if (dtcm_rsp_ready) begin
          if (cmd_hsk) begin
            state_d   = RSP;
            is_read_d = dtcm_cmd_read;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_d  = rsp_word;
          state_d = HOLD;
        end
      end

      HOLD: begin
        dtcm_rsp_valid = 1'b1;
        dtcm_rsp_rdata = hold_q;
        if (dtcm_rsp_ready) begin
          if (cmd_hsk) begin
            state_d   = RSP;
            is_read_d = dtcm_cmd_read;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dtcm_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dtcm_ctrl
// Self-checking bench for dtcm_ctrl. A reference model holds the memory image
// as a sparse word array and outstanding responses as an in-order queue; the
// DUT handshake signals and response data are compared against it every
// cycle during directed sequences and a randomized traffic phase.
// ----------------------------------------------------------------------------
module tb_dtcm_ctrl;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int DP = 2 ** (AW - 2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dtcm_cmd_valid;
  logic          dtcm_cmd_ready;
  logic          dtcm_cmd_read;
  logic [AW-1:0] dtcm_cmd_addr;
  logic [DW-1:0] dtcm_cmd_wdata;
  logic [3:0]    dtcm_cmd_wmask;
  logic          dtcm_rsp_valid;
  logic          dtcm_rsp_ready;
  logic [DW-1:0] dtcm_rsp_rdata;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: memory image and queue of responses still owed.
  logic [31:0] ref_mem [int];
  logic [31:0] exp_q [$];

  dtcm_ctrl #(
    .DW (DW),
    .AW (AW),
    .DP (DP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dtcm_cmd_valid (dtcm_cmd_valid),
    .dtcm_cmd_ready (dtcm_cmd_ready),
    .dtcm_cmd_read  (dtcm_cmd_read),
    .dtcm_cmd_addr  (dtcm_cmd_addr),
    .dtcm_cmd_wdata (dtcm_cmd_wdata),
    .dtcm_cmd_wmask (dtcm_cmd_wmask),
    .dtcm_rsp_valid (dtcm_rsp_valid),
    .dtcm_rsp_ready (dtcm_rsp_ready),
    .dtcm_rsp_rdata (dtcm_rsp_rdata)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expectation and keep the tallies.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end else begin
      pass_count++;
    end
  endtask

  // Drive one cycle of inputs (called just after a rising edge), check the
  // DUT outputs at the falling edge, then advance the model as of the next
  // rising edge: a queued response retires on rsp_ready, and a command is
  // accepted when nothing is owed or the owed response is retiring.
  task automatic applyStimulus(input logic v, input logic rd,
                               input logic [15:0] addr, input logic [31:0] wd,
                               input logic [3:0] wm, input logic rr);
    logic        exp_ready;
    logic        pending;
    int          idx;
    logic [31:0] word;
    dtcm_cmd_valid = v;
    dtcm_cmd_read  = rd;
    dtcm_cmd_addr  = addr;
    dtcm_cmd_wdata = wd;
    dtcm_cmd_wmask = wm;
    dtcm_rsp_ready = rr;
    @(negedge clk);
    pending   = (exp_q.size() != 0);
    exp_ready = !pending || rr;
    checkOutput("cmd_ready", {31'b0, dtcm_cmd_ready}, {31'b0, exp_ready});
    checkOutput("rsp_valid", {31'b0, dtcm_rsp_valid}, {31'b0, pending});
    if (pending) begin
      checkOutput("rsp_rdata", dtcm_rsp_rdata, exp_q[0]);
      if (rr) void'(exp_q.pop_front());
    end
    if (v && exp_ready) begin
      idx  = (int'(addr) / 4) % DP;
      word = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
      if (rd) begin
        exp_q.push_back(word);
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (wm[b]) word[b*8 +: 8] = wd[b*8 +: 8];
        end
        ref_mem[idx] = word;
        exp_q.push_back(32'h0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] r_addr;

    rst_n          = 1'b0;
    dtcm_cmd_valid = 1'b0;
    dtcm_cmd_read  = 1'b0;
    dtcm_cmd_addr  = '0;
    dtcm_cmd_wdata = '0;
    dtcm_cmd_wmask = '0;
    dtcm_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state on an idle bus.
    @(negedge clk);
    checkOutput("reset_cmd_ready", {31'b0, dtcm_cmd_ready}, 32'h1);
    checkOutput("reset_rsp_valid", {31'b0, dtcm_rsp_valid}, 32'h0);
    checkOutput("reset_rsp_rdata", dtcm_rsp_rdata, 32'h0);
    @(posedge clk);
    #1;

    // Write then immediate read of the same word.
    applyStimulus(1'b1, 1'b0, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h0010, 32'h0,        4'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0,        4'h0, 1'b1);

    // Single-lane write, read back through an unaligned address.
    applyStimulus(1'b1, 1'b0, 16'h0010, 32'h000000AA, 4'h1, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h0013, 32'h0,        4'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0,        4'h0, 1'b1);
    checkOutput("model_lane_merge", ref_mem[4], 32'hDEADBEAA);

    // Backpressure: restore the word, stall its read for three cycles while
    // a competing write is offered, then release and let the write in.
    applyStimulus(1'b1, 1'b0, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h0010, 32'h0,        4'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0010, 32'h12345678, 4'hF, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0010, 32'h12345678, 4'hF, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0010, 32'h12345678, 4'hF, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0010, 32'h12345678, 4'hF, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h0010, 32'h0,        4'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0,        4'h0, 1'b1);

    // Fill words 0..15 with distinct values, then 8 back-to-back reads.
    for (int w = 0; w < 16; w++) begin
      applyStimulus(1'b1, 1'b0, 16'(w * 4), 32'hA5000000 | 32'(w * 32'h01010101 + 7),
                    4'hF, 1'b1);
    end
    for (int w = 0; w < 8; w++) begin
      applyStimulus(1'b1, 1'b1, 16'(w * 4), 32'h0, 4'h0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1);

    // Randomized traffic over words 0..15 with random backpressure.
    for (int n = 0; n < 400; n++) begin
      r_addr = 16'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
                    r_addr, $urandom, 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 9) < 7));
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1);

    // Reset while a stalled response sits in the hold register.
    applyStimulus(1'b1, 1'b1, 16'h0008, 32'h0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_in_hold_rsp_valid", {31'b0, dtcm_rsp_valid}, 32'h0);
    checkOutput("reset_in_hold_rsp_rdata", dtcm_rsp_rdata, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h0008, 32'h0, 4'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h0010, 32'h0, 4'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/dtcm_ctrl.md
# dtcm_ctrl

Responder end of the LSU-to-DTCM command/response interface. Accepts one read or byte-masked write command at a time from the LSU, performs it on a single-port word SRAM, and returns exactly one response per accepted command, one cycle after acceptance. A response-hold register keeps the response stable under `dtcm_rsp_ready` backpressure. The block sits between the LSU controller and the data SRAM macro/model.

## Interface
- `DW`, default `XLEN` (32): data width. Must be 32.
- `AW`, default `DTCM_ADDR_WIDTH` (16): byte-address width.
- `DP`, default `2**(AW-2)`: SRAM depth in words.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `dtcm_cmd_valid`  in  1  command valid.
- `dtcm_cmd_ready`  out  1  command accepted when valid & ready.
- `dtcm_cmd_read`  in  1  1 = read, 0 = write.
- `dtcm_cmd_addr`  in  AW  byte address; bits [1:0] ignored.
- `dtcm_cmd_wdata`  in  DW  write data, already lane-aligned.
- `dtcm_cmd_wmask`  in  DW/8  byte-write enables; ignored for reads.
- `dtcm_rsp_valid`  out  1  response valid.
- `dtcm_rsp_ready`  in  1  response consumed when valid & ready.
- `dtcm_rsp_rdata`  out  DW  full read word; 0 for write responses.

## Operation
- Word index = `dtcm_cmd_addr[AW-1:2]`; no range check, index wraps modulo DP.
- Accept (cmd hsk): SRAM enabled; write updates only bytes with mask bit set; read latches the addressed word into the SRAM output register.
- Every accepted command, read or write, yields exactly one response, in order.
- FSM `IDLE`, `RSP`, `HOLD`:
  - `IDLE`: `rsp_valid`=0, `cmd_ready`=1. On cmd hsk -> `RSP`.
  - `RSP`: `rsp_valid`=1, rdata = SRAM output (read) or 0 (write). If `rsp_ready`: response retires; `cmd_ready`=1 in the same cycle; a new hsk -> `RSP`, otherwise -> `IDLE`. If not `rsp_ready`: capture rdata into the hold register -> `HOLD`; `cmd_ready`=0.
  - `HOLD`: `rsp_valid`=1, rdata = hold register; `cmd_ready` = `rsp_ready`. On `rsp_ready` with new hsk -> `RSP`; without -> `IDLE`.
- `cmd_ready` therefore = `(state==IDLE) | rsp_ready`. This path is combinational and intentionally supports back-to-back throughput.
- Store-then-load to the same word on consecutive accepts returns the newly written bytes.
- SRAM contents are not reset. Reset mid-response drops the pending response and returns to `IDLE`.

## Timing
- Reset values: `dtcm_rsp_valid`=0, `dtcm_rsp_rdata`=0, state `IDLE`, hold register 0. `dtcm_cmd_ready`=1 once `rst_n` is high.
- Latency: command accepted at edge N, response valid from cycle N+1.
- Throughput: 1 command/cycle while `rsp_ready` is held high.
- Under backpressure, `rsp_valid` and `rsp_rdata` stay constant until the response handshake completes.
- No command is accepted while a response is pending and `rsp_ready`=0.
- `rsp_valid` never depends combinationally on `cmd_valid`.

## Structure
- Shared `defines.v` supplies `XLEN` and `DTCM_ADDR_WIDTH`. Local FSM state encodings are `localparam`s in the module, not in the shared package.
- One sub-module: `gnrl_sram_1p` (params DW, DP, MW=DW/8; ports `clk`, `cs`, `we`, `wem`, `addr`, `din`, `dout`).
  - Registered `dout` updates only on `cs & ~we`.
  - Behavioral array for simulation; replaced by a macro wrapper in synthesis.
- `dtcm_ctrl` contains the FSM, hold register and rdata mux: ~150–200 lines total.

## Test plan
- Reset released, idle bus -> `cmd_ready`=1, `rsp_valid`=0, `rdata`=0.
- Write 0xDEADBEEF to addr 0x0010 with mask 0xF, then read 0x0010 on the next cycle with `rsp_ready`=1:
  - write response: `rsp_valid`=1, rdata=0.
  - read response: rdata=0xDEADBEEF, one cycle after its accept.
- Starting from word 0xDEADBEEF, write 0x000000AA with mask 0x1, then read addr 0x0013 -> 0xDEADBEAA; address bits [1:0] are ignored.
- Read 0x0010 with `rsp_ready`=0 for 3 cycles:
  - `rsp_valid`=1 and rdata=0xDEADBEEF stable throughout; `cmd_ready`=0.
  - Concurrently driven commands are not accepted.
  - On `rsp_ready`=1, a queued command is accepted in the same cycle.
- 8 back-to-back reads of consecutive words with `rsp_ready`=1 -> 8 in-order responses on 8 consecutive cycles, correct data.
- Assert `rst_n`=0 while in `HOLD` -> `rsp_valid`=0 immediately. After release, a read returns the prior SRAM contents (memory not cleared).
